vx_fpu_fflags_acc: RTL and testbench
====================================

# VX_fpu_fflags_acc

Accumulates RISC-V floating-point exception flags (NV, DZ, OF, UF, NX) produced by the FPU commit stage into per-warp sticky `fflags` registers. The block sits directly downstream of the FPU response path and upstream of the CSR unit. It OR-reduces per-lane flags across the active thread mask through a two-stage pipeline. It also tells the CSR unit when a warp's flags are still in flight, so the CSR unit can stall `fflags`/`fcsr` reads.

## Interface
- `NUM_WARPS`, 4: number of warps; one sticky register each.
- `NUM_THREADS`, 4: lanes per FPU commit.
- `WID_W`, derived: `max(1, clog2(NUM_WARPS))`.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `commit_valid`  in  1  FPU commit this cycle. Always accepted; there is no ready signal.
- `commit_wid`  in  WID_W  warp of the commit.
- `commit_tmask`  in  NUM_THREADS  active lanes.
- `commit_has_fflags`  in  1  instruction updates fflags. FP loads/stores/moves drive 0.
- `commit_fflags`  in  5*NUM_THREADS  lane i occupies bits [5i+4:5i], ordered NV,DZ,OF,UF,NX (bit 4..0).
- `csr_read_wid`  in  WID_W  warp being read.
- `csr_read_fflags`  out  5  sticky flags of `csr_read_wid`. Combinational from the sticky array, with no pipeline bypass.
- `csr_read_pending`  out  1  set when S0 or S1 holds a valid entry for `csr_read_wid`.
- `csr_write_valid`  in  1  CSR write/set/clear result for fflags.
- `csr_write_wid`  in  WID_W  warp being written.
- `csr_write_fflags`  in  5  full new value, already merged by the CSR unit.

## Operation
- S0 (input register) captures four things:
  - valid = `commit_valid & commit_has_fflags & |commit_tmask`
  - wid
  - tmask
  - raw lane flags
- S1 (reduce register) captures:
  - valid = S0 valid
  - wid
  - flags = bitwise OR over lanes i where tmask[i]=1 of lane i flags
- Sticky update, performed on every edge, for each warp w:
  - If `csr_write_valid` and `csr_write_wid==w`: sticky[w] <= `csr_write_fflags | (S1.valid && S1.wid==w ? S1.flags : 0)`.
  - Else if S1.valid and S1.wid==w: sticky[w] <= sticky[w] | S1.flags.
  - Else hold.
- The CSR write is ordered before the concurrent S1 commit. Flags from an instruction already in flight are never lost.
- Inactive lanes (tmask=0) never contribute, even if their flag bits are set.
- A valid entry with all-zero flags still occupies the pipeline and asserts pending. It leaves sticky unchanged.
- `csr_read_pending` = (S0.valid && S0.wid==csr_read_wid) || (S1.valid && S1.wid==csr_read_wid).
- The CSR unit must not complete a read while pending=1. The block does not enforce this.
- Out-of-range wid (>= NUM_WARPS when NUM_WARPS is not a power of two) is dropped in S1. It never writes sticky.

## Timing
- Reset, synchronous: S0.valid=0, S1.valid=0, all sticky=0. Consequently `csr_read_fflags`=0 and `csr_read_pending`=0 in the first cycle after reset.
- Reset asserted mid-operation discards in-flight S0/S1 entries. Reset has priority over a concurrent CSR write.
- Commit latency: a commit presented in cycle N sets pending from cycle N+1. It occupies S1 in cycle N+2 and is visible in `csr_read_fflags` from cycle N+3. Pending deasserts in cycle N+3 unless a later commit for the same warp is in flight.
- Throughput: one commit per cycle, with back-to-back commits to the same warp allowed. Each commit is ORed in on consecutive edges.
- A CSR write in cycle N is visible in `csr_read_fflags` from cycle N+1.
- The pipeline is never stalled. There is no backpressure in either direction.

## Test plan
- Reset, then read every warp: fflags=0 and pending=0 for all warps.
- Commit warp 1 with tmask=4'b0101, lane flags 0x10, 0x01, 0x04, 0x02 in cycle N:
  - pending(1)=1 in cycles N+1 and N+2, 0 in cycle N+3.
  - fflags(1)=0x14 from cycle N+3. Inactive-lane flags 0x01 and 0x02 are ignored.
- Back-to-back commits to warp 2, with flags 0x01 then 0x08 (all lanes active): fflags(2)=0x01 after the first lands, 0x09 after the second. Pending stays high continuously until the last commit lands.
- Sticky(3)=0x1F; CSR write wid 3 value 0x00 in the same cycle that S1 holds warp 3 flags 0x02: fflags(3)=0x02 next cycle. A concurrent S1 entry for warp 0 updates warp 0 independently.
- `commit_has_fflags`=0 or tmask=0 with nonzero flags: pending never asserts and sticky is unchanged.
- Reset asserted in the cycle a commit sits in S0: pending=0 and fflags=0 after reset, and the flags never appear.

Source files
------------

// File: rtl/vx_fpu_fflags_acc.sv
// -----------------------------------------------------------------------------
// vx_fpu_fflags_acc
//
// Collects the RISC-V floating-point exception flags (NV,DZ,OF,UF,NX in bits
// 4..0) from FPU commits into one sticky fflags register per warp. It also
// reports to the CSR unit when flags for a warp are still in flight.
//
// Pipeline:
//   S0 - registers the commit: valid, warp id, thread mask and raw lane flags.
//   S1 - ORs the flags of the active lanes together into one 5-bit value.
//   The sticky array is updated from S1 on the following edge.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   commit_valid        FPU commit this cycle (always accepted)
//   commit_wid          warp of the commit
//   commit_tmask        active lanes of the commit
//   commit_has_fflags   instruction produces fflags
//   commit_fflags       lane i flags in bits [5i+4:5i]
//   csr_read_wid        warp whose flags are read
//   csr_read_fflags     sticky flags of csr_read_wid (combinational, no bypass)
//   csr_read_pending    S0 or S1 holds a valid entry for csr_read_wid
//   csr_write_valid     CSR write of fflags
//   csr_write_wid       warp being written
//   csr_write_fflags    complete new fflags value
// -----------------------------------------------------------------------------
module vx_fpu_fflags_acc #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [WID_W-1:0]         commit_wid,
  input  logic [NUM_THREADS-1:0]   commit_tmask,
  input  logic                     commit_has_fflags,
  input  logic [5*NUM_THREADS-1:0] commit_fflags,
  input  logic [WID_W-1:0]         csr_read_wid,
  output logic [4:0]               csr_read_fflags,
  output logic                     csr_read_pending,
  input  logic                     csr_write_valid,
  input  logic [WID_W-1:0]         csr_write_wid,
  input  logic [4:0]               csr_write_fflags
);

  // S0 stage
  logic                     s0_valid_reg;
  logic [WID_W-1:0]         s0_wid_reg;
  logic [NUM_THREADS-1:0]   s0_tmask_reg;
  logic [5*NUM_THREADS-1:0] s0_fflags_reg;

  // S1 stage
  logic                     s1_valid_reg;
  logic [WID_W-1:0]         s1_wid_reg;
  logic [4:0]               s1_flags_reg;

  // Sticky per-warp flags
  logic [4:0] sticky_reg  [NUM_WARPS];
  logic [4:0] sticky_next [NUM_WARPS];

  logic [4:0] lane_masked [NUM_THREADS];
  logic [4:0] reduced_flags;
  logic       s0_wid_ok;
  logic       read_wid_ok;

  // Inactive lanes are forced to zero before the reduction, so set flag bits
  // on masked-off lanes can never reach the sticky register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
      assign lane_masked[gi] = s0_tmask_reg[gi] ? s0_fflags_reg[5*gi +: 5] : 5'd0;
    end
  endgenerate

  always_comb begin
    reduced_flags = 5'd0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      reduced_flags = reduced_flags | lane_masked[i];
    end
  end

  // A warp id is out of range only when NUM_WARPS is not a power of two.
  // Such entries are dropped when they move into S1, so they never touch sticky.
  generate
    if ((1 << WID_W) == NUM_WARPS) begin : g_wid_full
      assign s0_wid_ok   = 1'b1;
      assign read_wid_ok = 1'b1;
    end else begin : g_wid_partial
      assign s0_wid_ok   = (int'(s0_wid_reg) < NUM_WARPS);
      assign read_wid_ok = (int'(csr_read_wid) < NUM_WARPS);
    end
  endgenerate

  // The CSR write is applied first and the S1 commit is ORed on top, so flags
  // that are already in flight survive a concurrent write or clear.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      sticky_next[w] = sticky_reg[w];
      if (csr_write_valid && (csr_write_wid == WID_W'(w))) begin
        sticky_next[w] = csr_write_fflags |
                         ((s1_valid_reg && (s1_wid_reg == WID_W'(w))) ? s1_flags_reg : 5'd0);
      end else if (s1_valid_reg && (s1_wid_reg == WID_W'(w))) begin
        sticky_next[w] = sticky_reg[w] | s1_flags_reg;
      end
    end
  end

  // Control state and sticky array (reset)
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        sticky_reg[w] <= 5'd0;
      end
    end else begin
      s0_valid_reg <= commit_valid & commit_has_fflags & (|commit_tmask);
      s1_valid_reg <= s0_valid_reg & s0_wid_ok;
      for (int w = 0; w < NUM_WARPS; w++) begin
        sticky_reg[w] <= sticky_next[w];
      end
    end
  end

  // Payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    s0_wid_reg    <= commit_wid;
    s0_tmask_reg  <= commit_tmask;
    s0_fflags_reg <= commit_fflags;
    s1_wid_reg    <= s0_wid_reg;
    s1_flags_reg  <= reduced_flags;
  end

  assign csr_read_fflags  = read_wid_ok ? sticky_reg[csr_read_wid] : 5'd0;
  assign csr_read_pending = (s0_valid_reg && (s0_wid_reg == csr_read_wid)) ||
                            (s1_valid_reg && (s1_wid_reg == csr_read_wid));

endmodule

// File: tb/tb_vx_fpu_fflags_acc.sv
// -----------------------------------------------------------------------------
// tb_vx_fpu_fflags_acc
//
// Directed testbench for vx_fpu_fflags_acc (4 warps, 4 lanes). Inputs change
// 1 ns after a rising edge. Outputs are sampled 1 ns after csr_read_wid is set,
// so every sample falls well clear of the clock edge.
// -----------------------------------------------------------------------------
module tb_vx_fpu_fflags_acc;

  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int WID_W       = 2;

  logic                     clk;
  logic                     reset;
  logic                     commit_valid;
  logic [WID_W-1:0]         commit_wid;
  logic [NUM_THREADS-1:0]   commit_tmask;
  logic                     commit_has_fflags;
  logic [5*NUM_THREADS-1:0] commit_fflags;
  logic [WID_W-1:0]         csr_read_wid;
  logic [4:0]               csr_read_fflags;
  logic                     csr_read_pending;
  logic                     csr_write_valid;
  logic [WID_W-1:0]         csr_write_wid;
  logic [4:0]               csr_write_fflags;

  int tests_run = 0;
  int tests_failed = 0;

  vx_fpu_fflags_acc #(
    .NUM_WARPS   (NUM_WARPS),
    .NUM_THREADS (NUM_THREADS),
    .WID_W       (WID_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .commit_valid      (commit_valid),
    .commit_wid        (commit_wid),
    .commit_tmask      (commit_tmask),
    .commit_has_fflags (commit_has_fflags),
    .commit_fflags     (commit_fflags),
    .csr_read_wid      (csr_read_wid),
    .csr_read_fflags   (csr_read_fflags),
    .csr_read_pending  (csr_read_pending),
    .csr_write_valid   (csr_write_valid),
    .csr_write_wid     (csr_write_wid),
    .csr_write_fflags  (csr_write_fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    tests_run++;
    if (obs !== exp_val) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select a warp to read and let the combinational outputs settle
  task automatic rd(input int w);
    csr_read_wid = WID_W'(w);
    #1;
  endtask

  task automatic commit(input int w, input logic [3:0] tm, input logic has,
                        input logic [4:0] l0, input logic [4:0] l1,
                        input logic [4:0] l2, input logic [4:0] l3);
    commit_valid      = 1'b1;
    commit_wid        = WID_W'(w);
    commit_tmask      = tm;
    commit_has_fflags = has;
    commit_fflags     = {l3, l2, l1, l0};
  endtask

  task automatic idle_commit();
    commit_valid      = 1'b0;
    commit_has_fflags = 1'b0;
    commit_tmask      = '0;
    commit_fflags     = '0;
  endtask

  task automatic csr_write(input int w, input logic [4:0] v);
    csr_write_valid  = 1'b1;
    csr_write_wid    = WID_W'(w);
    csr_write_fflags = v;
  endtask

  initial begin
    reset = 1'b1;
    idle_commit();
    commit_wid       = '0;
    csr_read_wid     = '0;
    csr_write_valid  = 1'b0;
    csr_write_wid    = '0;
    csr_write_fflags = '0;
    #1;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      rd(w);
      check($sformatf("reset_fflags_w%0d", w), 32'(csr_read_fflags), 32'h0);
      check($sformatf("reset_pending_w%0d", w), 32'(csr_read_pending), 32'h0);
    end

    // Warp 1 commit; lanes 1 and 3 are inactive and must be ignored
    commit(1, 4'b0101, 1'b1, 5'h10, 5'h01, 5'h04, 5'h02);
    tick();
    idle_commit();
    rd(1);
    check("w1_pending_n1", 32'(csr_read_pending), 32'h1);
    check("w1_fflags_n1", 32'(csr_read_fflags), 32'h0);
    tick();
    rd(1);
    check("w1_pending_n2", 32'(csr_read_pending), 32'h1);
    check("w1_fflags_n2", 32'(csr_read_fflags), 32'h0);
    tick();
    rd(1);
    check("w1_pending_n3", 32'(csr_read_pending), 32'h0);
    check("w1_fflags_n3", 32'(csr_read_fflags), 32'h14);

    // Back-to-back commits to warp 2
    commit(2, 4'b1111, 1'b1, 5'h01, 5'h00, 5'h00, 5'h00);
    tick();
    commit(2, 4'b1111, 1'b1, 5'h00, 5'h00, 5'h08, 5'h00);
    rd(2);
    check("b2b_pending_n1", 32'(csr_read_pending), 32'h1);
    tick();
    idle_commit();
    rd(2);
    check("b2b_pending_n2", 32'(csr_read_pending), 32'h1);
    check("b2b_fflags_n2", 32'(csr_read_fflags), 32'h0);
    tick();
    rd(2);
    check("b2b_pending_n3", 32'(csr_read_pending), 32'h1);
    check("b2b_fflags_first", 32'(csr_read_fflags), 32'h01);
    tick();
    rd(2);
    check("b2b_pending_n4", 32'(csr_read_pending), 32'h0);
    check("b2b_fflags_second", 32'(csr_read_fflags), 32'h09);

    // Write sticky(3) = 0x1F
    csr_write(3, 5'h1F);
    tick();
    csr_write_valid = 1'b0;
    rd(3);
    check("w3_write_1f", 32'(csr_read_fflags), 32'h1F);

    // Clear warp 3 while S1 holds warp 3 flags 0x02: in-flight flags survive
    commit(3, 4'b1111, 1'b1, 5'h00, 5'h02, 5'h00, 5'h00);
    tick();
    idle_commit();
    tick();
    csr_write(3, 5'h00);
    tick();
    csr_write_valid = 1'b0;
    rd(3);
    check("w3_clear_vs_s1", 32'(csr_read_fflags), 32'h02);

    // Write warp 3 while S1 holds warp 0: both update independently
    commit(0, 4'b1000, 1'b1, 5'h00, 5'h00, 5'h00, 5'h08);
    tick();
    idle_commit();
    tick();
    csr_write(3, 5'h04);
    tick();
    csr_write_valid = 1'b0;
    rd(3);
    check("w3_write_other_s1", 32'(csr_read_fflags), 32'h04);
    rd(0);
    check("w0_concurrent_s1", 32'(csr_read_fflags), 32'h08);

    // has_fflags=0 with nonzero flags: no effect
    commit(0, 4'b1111, 1'b0, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
    tick();
    idle_commit();
    rd(0);
    check("nohas_pending_n1", 32'(csr_read_pending), 32'h0);
    tick();
    rd(0);
    check("nohas_pending_n2", 32'(csr_read_pending), 32'h0);
    tick();
    rd(0);
    check("nohas_fflags", 32'(csr_read_fflags), 32'h08);

    // tmask=0 with nonzero flags: no effect
    commit(1, 4'b0000, 1'b1, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
    tick();
    idle_commit();
    rd(1);
    check("tm0_pending_n1", 32'(csr_read_pending), 32'h0);
    tick();
    rd(1);
    check("tm0_pending_n2", 32'(csr_read_pending), 32'h0);
    tick();
    rd(1);
    check("tm0_fflags", 32'(csr_read_fflags), 32'h14);

    // Reset while a warp 2 commit sits in S0, together with a CSR write
    commit(2, 4'b1111, 1'b1, 5'h10, 5'h00, 5'h00, 5'h00);
    tick();
    idle_commit();
    reset = 1'b1;
    csr_write(0, 5'h1F);
    tick();
    reset = 1'b0;
    csr_write_valid = 1'b0;
    rd(2);
    check("rst_mid_pending", 32'(csr_read_pending), 32'h0);
    check("rst_mid_fflags", 32'(csr_read_fflags), 32'h0);
    rd(0);
    check("rst_over_write", 32'(csr_read_fflags), 32'h0);
    rd(1);
    check("rst_clears_w1", 32'(csr_read_fflags), 32'h0);
    tick();
    tick();
    rd(2);
    check("rst_flags_never_land", 32'(csr_read_fflags), 32'h0);
    check("rst_pending_later", 32'(csr_read_pending), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
